matrix_iter_ctrl: RTL and testbench

//  Iteration controller directly downstream of (and looping back into) the 4-state maxtrix stage.

---
 rtl/matrix_iter_ctrl.sv | 163 ++++++++++++++++
 tb/tb_matrix_iter_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_iter_ctrl.sv
// Iteration controller for the 4-state maxtrix stage: launches steps, feeds results back, stops on convergence or cap.
// Optional mx_done watchdog enabled with `define MATRIX_ITER_WDOG_EN.
//
// state  | meaning
// IDLE   | waiting for go; result, iteration count and flags held
// LAUNCH | one-cycle mx_start with current vector on mx_x*
// WAIT   | waiting for mx_done (or watchdog expiry)
// CHECK  | compare new vector against old, adopt new vector
// DONE   | one-cycle done pulse, result presented
module matrix_iter_ctrl #(
    parameter int unsigned W        = 32,
    parameter int unsigned TOL      = 16,
    parameter int unsigned MAX_ITER = 255,
    parameter int unsigned WDOG_CYC = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [W-1:0] init_xp,
    input  logic [W-1:0] init_xs,
    input  logic [W-1:0] init_xl,
    input  logic [W-1:0] init_xti,
    output logic         mx_start,
    output logic [W-1:0] mx_xp,
    output logic [W-1:0] mx_xs,
    output logic [W-1:0] mx_xl,
    output logic [W-1:0] mx_xti,
    input  logic         mx_done,
    input  logic [W-1:0] mx_xpn,
    input  logic [W-1:0] mx_xsn,
    input  logic [W-1:0] mx_xln,
    input  logic [W-1:0] mx_xtin,
    output logic         busy,
    output logic         done,
    output logic         converged,
    output logic         timeout,
    output logic [7:0]   iter_cnt,
    output logic [W-1:0] res_xp,
    output logic [W-1:0] res_xs,
    output logic [W-1:0] res_xl,
    output logic [W-1:0] res_xti
);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CHECK, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [3:0][W-1:0]   cur, nxt, res;
    logic [3:0][W-1:0]   init_v, new_v;
    logic                all_close;
    logic                at_cap;
    logic                wdog_hit;

    assign init_v = {init_xti, init_xl, init_xs, init_xp};
    assign new_v  = {mx_xtin, mx_xln, mx_xsn, mx_xpn};
    assign at_cap = (iter_cnt == 8'(MAX_ITER));

    // Magnitude taken by ordering the operands first so the difference never wraps.
    always_comb begin
        all_close = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (nxt[i] >= cur[i]) begin
                if ((nxt[i] - cur[i]) > W'(TOL)) all_close = 1'b0;
            end else begin
                if ((cur[i] - nxt[i]) > W'(TOL)) all_close = 1'b0;
            end
        end
    end

`ifdef MATRIX_ITER_WDOG_EN
    logic [15:0] wdog_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                wdog_cnt <= '0;
        else if (state == S_LAUNCH) wdog_cnt <= '0;
        else if (state == S_WAIT)   wdog_cnt <= wdog_cnt + 16'd1;
    end

    assign wdog_hit = (state == S_WAIT) && !mx_done && (wdog_cnt == 16'(WDOG_CYC - 1));
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (go) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT: begin
                if (mx_done)       state_nxt = S_CHECK;
                else if (wdog_hit) state_nxt = S_DONE;
            end
            S_CHECK:  state_nxt = (all_close || at_cap) ? S_DONE : S_LAUNCH;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Result is loaded on the way into DONE so it is already valid while done pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= '0;
            nxt       <= '0;
            res       <= '0;
            iter_cnt  <= '0;
            converged <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        cur       <= init_v;
                        iter_cnt  <= '0;
                        converged <= 1'b0;
                        timeout   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mx_done) begin
                        nxt      <= new_v;
                        iter_cnt <= iter_cnt + 8'd1;
                    end else if (wdog_hit) begin
                        timeout   <= 1'b1;
                        converged <= 1'b0;
                        res       <= cur;
                    end
                end
                S_CHECK: begin
                    cur <= nxt;
                    if (all_close) begin
                        converged <= 1'b1;
                        res       <= nxt;
                    end else if (at_cap) begin
                        converged <= 1'b0;
                        res       <= nxt;
                    end
                end
                S_DONE:  res <= cur;
                default: ;
            endcase
        end
    end

    assign mx_start = (state == S_LAUNCH);
    assign done     = (state == S_DONE);
    assign busy     = (state != S_IDLE);
    assign mx_xp    = cur[0];
    assign mx_xs    = cur[1];
    assign mx_xl    = cur[2];
    assign mx_xti   = cur[3];
    assign res_xp   = res[0];
    assign res_xs   = res[1];
    assign res_xl   = res[2];
    assign res_xti  = res[3];

endmodule

// File: tb/tb_matrix_iter_ctrl.sv
// Scoreboard bench for matrix_iter_ctrl: behavioural maxtrix model driven by per-step delta tables.
// Watchdog run included when compiled with MATRIX_ITER_WDOG_EN.
module tb_matrix_iter_ctrl;

    localparam int W    = 32;
    localparam int TOL  = 16;
    localparam int MAXI = 4;
    localparam int WDOG = 64;

    typedef struct packed {
        logic [7:0]        iter;
        logic              conv;
        logic              tmo;
        logic [3:0][31:0]  res;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n, go, mx_done, mx_start, busy, done, converged, timeout;
    logic [3:0][31:0]  init_v, xn_v;
    logic [W-1:0]      mx_xp, mx_xs, mx_xl, mx_xti;
    logic [W-1:0]      res_xp, res_xs, res_xl, res_xti;
    logic [7:0]        iter_cnt;

    int   total = 0, bad = 0;
    int   dtab[MAXI][4];
    int   mstep;
    bit   never_done;
    exp_t sb[$];
    int   cyc = 0, starts = 0, last_done_cyc = 0, start_cyc = 0;

    always #5 clk = ~clk;

    matrix_iter_ctrl #(.W(W), .TOL(TOL), .MAX_ITER(MAXI), .WDOG_CYC(WDOG)) dut (
        .clk(clk), .rst_n(rst_n), .go(go),
        .init_xp(init_v[0]), .init_xs(init_v[1]), .init_xl(init_v[2]), .init_xti(init_v[3]),
        .mx_start(mx_start), .mx_xp(mx_xp), .mx_xs(mx_xs), .mx_xl(mx_xl), .mx_xti(mx_xti),
        .mx_done(mx_done),
        .mx_xpn(xn_v[0]), .mx_xsn(xn_v[1]), .mx_xln(xn_v[2]), .mx_xtin(xn_v[3]),
        .busy(busy), .done(done), .converged(converged), .timeout(timeout), .iter_cnt(iter_cnt),
        .res_xp(res_xp), .res_xs(res_xs), .res_xl(res_xl), .res_xti(res_xti)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Reference: iterate x <- x + delta[k] until every |change| <= TOL or the cap is hit.
    function automatic exp_t ref_run(input logic [3:0][31:0] iv, input bit hang);
        exp_t e;
        logic [3:0][31:0] x, xn;
        logic [31:0] d;
        bit close;
        e = '0;
        x = iv;
        if (hang) begin
            e.tmo = 1'b1;
            e.res = iv;
            return e;
        end
        for (int k = 0; k < MAXI; k++) begin
            close = 1'b1;
            for (int i = 0; i < 4; i++) begin
                xn[i] = x[i] + dtab[k][i];
                d = (x[i] >= xn[i]) ? x[i] - xn[i] : xn[i] - x[i];
                if (d > TOL) close = 1'b0;
            end
            x = xn;
            e.iter = 8'(k + 1);
            if (close) begin
                e.conv = 1'b1;
                break;
            end
        end
        e.res = x;
        return e;
    endfunction

    // Maxtrix model: answers each mx_start three cycles later using the delta table.
    initial begin
        logic [3:0][31:0] xin;
        int k;
        mx_done = 1'b0;
        xn_v = '0;
        forever begin
            @(posedge clk); #1;
            if (mx_start && !never_done) begin
                xin = {mx_xti, mx_xl, mx_xs, mx_xp};
                k = mstep;
                mstep++;
                repeat (3) @(posedge clk);
                #1;
                for (int i = 0; i < 4; i++)
                    xn_v[i] = xin[i] + ((k < MAXI) ? dtab[k][i] : 0);
                mx_done = 1'b1;
                @(posedge clk); #1;
                mx_done = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (go && !busy && rst_n) starts = 0;
            if (mx_done) last_done_cyc = cyc;
            if (mx_start) begin
                starts++;
                if (starts > 1) chk("done_to_start", 64'(cyc - last_done_cyc), 64'd2);
                start_cyc = cyc;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("iter_cnt", 64'(iter_cnt), 64'(e.iter));
                    chk("converged", 64'(converged), 64'(e.conv));
                    chk("timeout", 64'(timeout), 64'(e.tmo));
                    chk("res_xp", 64'(res_xp), 64'(e.res[0]));
                    chk("res_xs", 64'(res_xs), 64'(e.res[1]));
                    chk("res_xl", 64'(res_xl), 64'(e.res[2]));
                    chk("res_xti", 64'(res_xti), 64'(e.res[3]));
                    chk("start_count", 64'(starts), e.tmo ? 64'(e.iter) + 64'd1 : 64'(e.iter));
                    if (e.tmo) chk("wdog_latency", 64'(cyc - start_cyc), 64'(WDOG + 1));
                    else       chk("done_latency", 64'(cyc - last_done_cyc), 64'd2);
                end
            end
        end
    end

    task automatic clear_tab();
        for (int k = 0; k < MAXI; k++)
            for (int i = 0; i < 4; i++) dtab[k][i] = 0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (done) return;
        end
        chk("done_wait_expired", 64'd1, 64'd0);
    endtask

    task automatic run(input logic [3:0][31:0] iv, input bit hang, input bit extra_go);
        init_v = iv;
        never_done = hang;
        mstep = 0;
        sb.push_back(ref_run(iv, hang));
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        if (extra_go) begin
            repeat (2) @(posedge clk);
            #1 go = 1'b1;
            @(posedge clk); #1 go = 1'b0;
        end
        wait_done();
    endtask

    logic [3:0][31:0] base;

    initial begin
        rst_n = 1'b0;
        go = 1'b0;
        never_done = 1'b0;
        mstep = 0;
        init_v = '0;
        clear_tab();
        base = {32'd63464, 32'd436436, 32'd124241, 32'd1412442};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_start", 64'(mx_start), 64'd0);
        chk("rst_iter", 64'(iter_cnt), 64'd0);
        chk("rst_flags", 64'({converged, timeout}), 64'd0);
        chk("rst_res", 64'(res_xp | res_xs | res_xl | res_xti), 64'd0);
        rst_n = 1'b1;

        run(base, 1'b0, 1'b0);
        chk("t1_iter", 64'(iter_cnt), 64'd1);
        chk("t1_res_xp", 64'(res_xp), 64'd1412442);

        clear_tab();
        for (int k = 0; k < 3; k++) dtab[k][0] = 100;
        run(base, 1'b0, 1'b0);
        chk("t2_res_xp", 64'(res_xp), 64'd1412742);

        clear_tab();
        dtab[0][1] = 16;
        run(base, 1'b0, 1'b0);
        clear_tab();
        dtab[0][1] = -17;
        run(base, 1'b0, 1'b0);
        chk("t3_iter", 64'(iter_cnt), 64'd2);

        clear_tab();
        for (int k = 0; k < MAXI; k++) dtab[k][2] = 1000;
        run(base, 1'b0, 1'b0);
        chk("t4_res_xl", 64'(res_xl), 64'd440436);
        chk("t4_conv", 64'(converged), 64'd0);

        clear_tab();
        for (int k = 0; k < 3; k++) dtab[k][0] = 100;
        run(base, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("t5_no_rerun", 64'(busy), 64'd0);

        clear_tab();
        init_v = base;
        mstep = 0;
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mx_start) break;
        end
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_res", 64'(res_xp | res_xs | res_xl | res_xti), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);

        for (int r = 0; r < 12; r++) begin
            logic [3:0][31:0] iv;
            for (int i = 0; i < 4; i++) iv[i] = $urandom;
            for (int k = 0; k < MAXI; k++) begin
                bit calm;
                calm = ($urandom_range(0, 1) == 0);
                for (int i = 0; i < 4; i++) begin
                    case (calm ? $urandom_range(0, 1) : $urandom_range(0, 3))
                        0:       dtab[k][i] = 0;
                        1:       dtab[k][i] = $urandom_range(0, 2 * TOL) - TOL;
                        2:       dtab[k][i] = ($urandom_range(0, 1) == 0) ? TOL + 1 : -(TOL + 1);
                        default: dtab[k][i] = int'($urandom);
                    endcase
                end
            end
            run(iv, 1'b0, 1'b0);
        end

`ifdef MATRIX_ITER_WDOG_EN
        clear_tab();
        run(base, 1'b1, 1'b0);
        chk("t6_timeout", 64'(timeout), 64'd1);
        never_done = 1'b0;
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
